// File: rtl/piano_note_arbiter.sv
// Purpose : debounces eight piano keys, picks the single note that owns the speaker,
//           and drives one shared square-wave tone divider for that note.
// Latency : raw key edge -> debounced edge 2+DEBOUNCE_CYCLES cycles; +2 more until note_valid.
// Backpressure: none; keys are level inputs and the outputs are free-running levels.
//
// Ports:
//   clk         system clock (50 MHz)
//   rst         asynchronous reset, active-high
//   keys[7:0]   raw active-high keys, bit0 = Do (C4) ... bit7 = Do' (C5)
//   octave_up   (only with OCTAVE_UP_EN) halves the loaded half-period, raising one octave
//   speaker     square-wave tone output
//   note_valid  high while a note is playing
//   active_note index of the key owning the speaker
//
// Optional feature macro: OCTAVE_UP_EN
module piano_note_arbiter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys,
`ifdef OCTAVE_UP_EN
    input  logic       octave_up,
`endif
    output logic       speaker,
    output logic       note_valid,
    output logic [2:0] active_note
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       key_s1;
    logic [7:0]       key_s2;
    logic [7:0]       deb;
    logic [7:0]       deb_d;
    logic [DW-1:0]    dcnt [8];
    logic [2:0]       own;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] tcnt;

    logic [7:0]       press;
    logic [7:0]       rel;
    logic             sel_ev;
    logic             idle_ev;
    logic [2:0]       new_sel;
    logic [2:0]       load_idx;
    logic [CNT_W-1:0] tbl_val;
    logic             oct_hi;
    logic             oct_chg;

    // Half-period of each note in clk cycles.
    function automatic logic [CNT_W-1:0] note_half(input logic [2:0] idx);
        case (idx)
            3'd0:    note_half = CNT_W'(95556);
            3'd1:    note_half = CNT_W'(85132);
            3'd2:    note_half = CNT_W'(75843);
            3'd3:    note_half = CNT_W'(71586);
            3'd4:    note_half = CNT_W'(63776);
            3'd5:    note_half = CNT_W'(56818);
            3'd6:    note_half = CNT_W'(50620);
            default: note_half = CNT_W'(47778);
        endcase
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    // Two-flop synchronizer on every key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            key_s1 <= keys;
            key_s2 <= key_s1;
        end
    end

    // A key's debounced value only moves after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 8; i++) dcnt[i] <= '0;
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 8; i++) begin
                if (key_s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    deb[i]  <= key_s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

`ifdef OCTAVE_UP_EN
    logic oct_s1;
    logic oct_s2;
    logic oct_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oct_s1 <= 1'b0;
            oct_s2 <= 1'b0;
            oct_d  <= 1'b0;
        end else begin
            oct_s1 <= octave_up;
            oct_s2 <= oct_s1;
            oct_d  <= oct_s2;
        end
    end

    assign oct_hi  = oct_s2;
    assign oct_chg = oct_s2 != oct_d;
`else
    assign oct_hi  = 1'b0;
    assign oct_chg = 1'b0;
`endif

    // Arbitration: a press always wins (lowest index on ties); releasing the owner falls
    // back to the lowest held key, or silences when nothing is held. Own is only
    // meaningful outside IDLE.
    always_comb begin
        press   = deb & ~deb_d;
        rel     = deb_d & ~deb;
        sel_ev  = 1'b0;
        idle_ev = 1'b0;
        new_sel = 3'd0;
        if (|press) begin
            sel_ev  = 1'b1;
            new_sel = lowest_set(press);
        end else if (state != IDLE && rel[own]) begin
            if (|deb) begin
                sel_ev  = 1'b1;
                new_sel = lowest_set(deb);
            end else begin
                idle_ev = 1'b1;
            end
        end
        // An event landing during LOAD retargets the load in the same cycle.
        load_idx = sel_ev ? new_sel : own;
        tbl_val  = note_half(load_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            own         <= 3'd0;
            active_note <= 3'd0;
            half_q      <= '0;
            tcnt        <= '0;
            speaker     <= 1'b0;
            note_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    speaker    <= 1'b0;
                    note_valid <= 1'b0;
                    if (sel_ev) begin
                        own   <= new_sel;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (idle_ev) begin
                        speaker    <= 1'b0;
                        note_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        own         <= load_idx;
                        active_note <= load_idx;
                        half_q      <= oct_hi ? (tbl_val >> 1) : tbl_val;
                        tcnt        <= '0;
                        speaker     <= 1'b0;
                        note_valid  <= 1'b1;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    if (sel_ev) begin
                        own     <= new_sel;
                        speaker <= 1'b0;
                        state   <= LOAD;
                    end else if (idle_ev) begin
                        speaker    <= 1'b0;
                        note_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (oct_chg) begin
                        // Same note, new octave: reload to pick up the new half-period.
                        speaker <= 1'b0;
                        state   <= LOAD;
                    end else if (tcnt == half_q - CNT_W'(1)) begin
                        speaker <= ~speaker;
                        tcnt    <= '0;
                    end else begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piano_note_arbiter.sv
module tb_piano_note_arbiter;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keys;
    logic       speaker;
    logic       note_valid;
    logic [2:0] active_note;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    piano_note_arbiter #(.DEBOUNCE_CYCLES(DB), .CNT_W(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .keys        (keys),
`ifdef OCTAVE_UP_EN
        .octave_up   (1'b0),
`endif
        .speaker     (speaker),
        .note_valid  (note_valid),
        .active_note (active_note)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         half_tbl [8] = '{95556, 85132, 75843, 71586, 63776, 56818, 50620, 47778};
    logic [7:0] m_s1, m_s2, m_db, m_dbd;
    logic [7:0] win [$];
    int         m_own;     // owning key, -1 when silent
    bit         m_pend;    // a note load is due at the next edge
    bit         m_snd;     // a note has been loaded and is sounding
    int         m_load_at;
    int         m_half;
    int         n;
    logic       m_spk;
    logic       m_nv;
    logic [2:0] m_act;

    function automatic int lowest(input logic [7:0] v);
        int r = -1;
        for (int i = 7; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic void m_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_dbd = '0;
        win.delete();
        for (int i = 0; i < DB; i++) win.push_back(8'h00);
        m_own = -1; m_pend = 0; m_snd = 0; m_load_at = 0; m_half = 1; n = 0;
        m_spk = 0; m_nv = 0; m_act = 3'd0;
    endfunction

    function automatic void m_step(input logic [7:0] raw);
        logic [7:0] press, rel, nd;
        int choose;
        bit silence;
        bit all_diff;
        press   = m_db & ~m_dbd;
        rel     = m_dbd & ~m_db;
        choose  = -1;
        silence = 0;
        if (press != 0) choose = lowest(press);
        else if (m_own >= 0 && rel[m_own]) begin
            if (m_db != 0) choose = lowest(m_db);
            else silence = 1;
        end
        if (m_pend) begin
            m_pend = 0;
            if (silence) begin
                m_own = -1; m_snd = 0; m_spk = 0; m_nv = 0;
            end else begin
                if (choose >= 0) m_own = choose;
                m_act = m_own[2:0]; m_half = half_tbl[m_own]; m_load_at = n;
                m_snd = 1; m_spk = 0; m_nv = 1;
            end
        end else if (choose >= 0) begin
            m_own = choose; m_pend = 1; m_spk = 0;
        end else if (silence) begin
            m_own = -1; m_snd = 0; m_spk = 0; m_nv = 0;
        end else if (m_snd) begin
            m_spk = (((n - m_load_at) / m_half) % 2) == 1;
        end
        // debounced bit flips once the last DB synchronized samples all disagree with it
        win.push_back(m_s2);
        void'(win.pop_front());
        nd = m_db;
        for (int k = 0; k < 8; k++) begin
            all_diff = 1;
            foreach (win[j]) if (win[j][k] == m_db[k]) all_diff = 0;
            if (all_diff) nd[k] = ~m_db[k];
        end
        m_dbd = m_db;
        m_db  = nd;
        m_s2  = m_s1;
        m_s1  = raw;
        n++;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step(keys);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("model_speaker", int'(speaker), int'(m_spk));
                check("model_note_valid", int'(note_valid), int'(m_nv));
                check("model_active_note", int'(active_note), int'(m_act));
            end
        end
    end

    task automatic wait_nv(input logic want, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (note_valid !== want && cyc < budget);
    endtask

    task automatic idle_cycles(input int cnt, output int nv_hi, output int spk_hi);
        nv_hi = 0; spk_hi = 0;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            nv_hi  += int'(note_valid);
            spk_hi += int'(speaker);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, nvh, sph, hold, r;
        rst  = 1'b1;
        keys = 8'h00;
        @(posedge clk);
        started = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_speaker", int'(speaker), 0);
        check("reset_note_valid", int'(note_valid), 0);
        check("reset_active_note", int'(active_note), 0);
        @(negedge clk);
        rst = 1'b0;

        // idle with no keys
        idle_cycles(1000, nvh, sph);
        check("idle_note_valid_cycles", nvh, 0);
        check("idle_speaker_cycles", sph, 0);

        // single note La: 2 sync + 4 debounce + 2 arbitration/load
        keys = 8'h20;
        wait_nv(1'b1, 40, cyc);
        check("la_latency", cyc, 8);
        check("la_active_note", int'(active_note), 5);
        cyc = 0;
        while (speaker !== 1'b1 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        check("la_first_toggle", cyc, 56818);
        check("la_note_valid_held", int'(note_valid), 1);
        keys = 8'h00;
        wait_nv(1'b0, 30, cyc);
        check("la_release_note_valid", int'(note_valid), 0);
        check("la_release_speaker", int'(speaker), 0);

        // bounce rejection
        nvh = 0; sph = 0;
        for (int i = 0; i < 20; i++) begin
            keys = {7'd0, ~keys[0]};
            repeat (2) begin
                @(negedge clk);
                nvh += int'(note_valid);
                sph += int'(speaker);
            end
        end
        keys = 8'h00;
        idle_cycles(20, cyc, hold);
        check("bounce_note_valid_cycles", nvh + cyc, 0);
        check("bounce_speaker_cycles", sph + hold, 0);

        // newest press wins, fallback on release of owner, idle on last release
        keys = 8'h01;
        wait_nv(1'b1, 40, cyc);
        check("hold0_active", int'(active_note), 0);
        keys = 8'h11;
        repeat (12) @(negedge clk);
        check("press4_active", int'(active_note), 4);
        check("press4_valid", int'(note_valid), 1);
        keys = 8'h01;
        repeat (12) @(negedge clk);
        check("fallback0_active", int'(active_note), 0);
        check("fallback0_valid", int'(note_valid), 1);
        keys = 8'h00;
        repeat (12) @(negedge clk);
        check("release_all_valid", int'(note_valid), 0);

        // simultaneous press, lowest index wins
        keys = 8'h81;
        repeat (12) @(negedge clk);
        check("simul_active", int'(active_note), 0);
        check("simul_valid", int'(note_valid), 1);

        // asynchronous reset mid-tone, then fresh debounce
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_speaker", int'(speaker), 0);
        check("async_rst_note_valid", int'(note_valid), 0);
        check("async_rst_active", int'(active_note), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_nv(1'b1, 40, cyc);
        check("post_rst_latency", cyc, 8);
        check("post_rst_active", int'(active_note), 0);

        // randomized key activity against the model
        for (int step = 0; step < 900; step++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: keys = 8'($urandom);
                1, 2: keys = keys ^ (8'h01 << $urandom_range(0, 7));
                default: keys = 8'h00;
            endcase
            hold = $urandom_range(1, 10);
            repeat (hold) @(negedge clk);
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
        end
        keys = 8'h00;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
